clkdiv_phase_ctrl: RTL and testbench

Sequencer for the 100 MHz→28 MHz (÷3.5) clock-divider primitive. Runs on the 100 MHz source clock. It holds the divider in reset until the PLL lock has been stable, then releases it. It then steps the divider's CALIB input until an external phase comparator reports the 28 MHz output aligned to the bus reference, and only then asserts `div_ready` to downstream logic. It owns the divider's `resetn` and `calib` pins; nothing else drives them.

---
 rtl/clkdiv_phase_ctrl.sv | 162 ++++++++++++++++
 tb/tb_clkdiv_phase_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_phase_ctrl.sv
// clkdiv_phase_ctrl
// -----------------------------------------------------------------------------
// Bring-up sequencer for the 100 MHz -> 28 MHz (/3.5) clock-divider primitive.
// Runs on the 100 MHz source clock. The divider is held in reset until the PLL
// lock has been stable for LOCK_STABLE_CYCLES cycles. It is then released and
// allowed to settle. After that, CALIB is stepped one pulse at a time until the
// external phase comparator reports alignment. div_ready is raised only once
// alignment is reached. If MAX_CALIB pulses are not enough, the block parks in
// a fault state.
//
// Ports
//   clk           in   100 MHz source clock (same net as divider HCLKIN)
//   rst           in   synchronous active-high reset
//   pll_lock      in   PLL lock, already synchronised to clk
//   relock_req    in   single-cycle request to restart the whole sequence
//   phase_valid   in   comparator strobe; phase_ok is meaningful when high
//   phase_ok      in   1 = divider output aligned to the bus reference
//   clkdiv_resetn out  divider RESETN (registered)
//   clkdiv_calib  out  divider CALIB (registered, single-cycle pulses)
//   div_ready     out  28 MHz domain usable
//   calib_count   out  CALIB pulses issued in the current attempt
//   fault         out  alignment not reached within MAX_CALIB pulses
// -----------------------------------------------------------------------------
module clkdiv_phase_ctrl #(
  parameter int LOCK_STABLE_CYCLES = 1024,  // >= 2
  parameter int SETTLE_CYCLES      = 16,    // >= 1
  parameter int CALIB_GAP          = 8,     // >= 1
  parameter int MAX_CALIB          = 7      // 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       relock_req,
  input  logic       phase_valid,
  input  logic       phase_ok,
  output logic       clkdiv_resetn,
  output logic       clkdiv_calib,
  output logic       div_ready,
  output logic [3:0] calib_count,
  output logic       fault
);

  // The lock counter only has to reach LOCK_STABLE_CYCLES-1.
  localparam int LW   = $clog2(LOCK_STABLE_CYCLES);
  // One timer is shared by SETTLE and CALIB. It must hold up to CALIB_GAP.
  localparam int TMAX = (SETTLE_CYCLES > CALIB_GAP) ? SETTLE_CYCLES : CALIB_GAP;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_SETTLE,
    S_CHECK,
    S_CALIB,
    S_READY,
    S_FAULT
  } state_t;

  state_t        state;
  logic [LW-1:0] lock_cnt;
  logic [TW-1:0] timer;

  // The outputs are registered alongside the state. Each transition writes the
  // output values of the state it enters, so the pins change on the same edge
  // as the state.
  // NOTE: every register here uses non-blocking assignments. Blocking
  // assignments would let later statements see the new values within the
  // same edge and create simulation/synthesis mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_WAIT_LOCK;
      lock_cnt      <= '0;
      timer         <= '0;
      calib_count   <= '0;
      clkdiv_resetn <= 1'b0;
      clkdiv_calib  <= 1'b0;
      div_ready     <= 1'b0;
      fault         <= 1'b0;
    end else if (relock_req || (state != S_WAIT_LOCK && !pll_lock)) begin
      // Lock loss or relock restarts from scratch. This takes priority over
      // any comparator strobe on the same edge, and also cuts a CALIB pulse
      // short.
      state         <= S_WAIT_LOCK;
      lock_cnt      <= '0;
      timer         <= '0;
      calib_count   <= '0;
      clkdiv_resetn <= 1'b0;
      clkdiv_calib  <= 1'b0;
      div_ready     <= 1'b0;
      fault         <= 1'b0;
    end else begin
      // CALIB is high only in the cycle right after entering S_CALIB.
      clkdiv_calib <= 1'b0;

      case (state)
        S_WAIT_LOCK: begin
          if (!pll_lock) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LW'(LOCK_STABLE_CYCLES - 1)) begin
            state         <= S_SETTLE;
            lock_cnt      <= '0;
            timer         <= '0;
            clkdiv_resetn <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end

        S_SETTLE: begin
          if (timer == TW'(SETTLE_CYCLES - 1)) begin
            state <= S_CHECK;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_CHECK: begin
          if (phase_valid) begin
            if (phase_ok) begin
              state     <= S_READY;
              div_ready <= 1'b1;
            end else if (calib_count < 4'(MAX_CALIB)) begin
              state        <= S_CALIB;
              clkdiv_calib <= 1'b1;
              calib_count  <= calib_count + 4'd1;
              timer        <= '0;
            end else begin
              state <= S_FAULT;
              fault <= 1'b1;
            end
          end
        end

        S_CALIB: begin
          // The pulse cycle plus CALIB_GAP blind cycles. phase_valid is
          // ignored for the whole time.
          if (timer == TW'(CALIB_GAP)) begin
            state <= S_CHECK;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_READY, S_FAULT: begin
          // Hold until lock loss, relock request or reset.
        end

        default: begin
          state         <= S_WAIT_LOCK;
          lock_cnt      <= '0;
          timer         <= '0;
          calib_count   <= '0;
          clkdiv_resetn <= 1'b0;
          div_ready     <= 1'b0;
          fault         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_phase_ctrl.sv
// tb_clkdiv_phase_ctrl
// -----------------------------------------------------------------------------
// Directed bench for clkdiv_phase_ctrl with LOCK_STABLE_CYCLES=8,
// SETTLE_CYCLES=4, CALIB_GAP=3 and MAX_CALIB=7.
//
// "Edge N" is the rising edge at which an input change is applied. Inputs are
// driven 1 ns after that edge and are first sampled at edge N+1. Outputs are
// read 1 ns after an edge.
// -----------------------------------------------------------------------------
module tb_clkdiv_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       relock_req;
  logic       phase_valid;
  logic       phase_ok;
  logic       clkdiv_resetn;
  logic       clkdiv_calib;
  logic       div_ready;
  logic [3:0] calib_count;
  logic       fault;

  int total = 0;
  int bad   = 0;

  // CALIB pulse monitor, sampled on the falling edge.
  int  cyc        = 0;
  int  pulses     = 0;
  int  run_len    = 0;
  int  max_run    = 0;
  int  last_start = -1;
  int  min_space  = 1000000;
  logic prev_calib = 1'b0;

  always #5 clk = ~clk;

  clkdiv_phase_ctrl #(
    .LOCK_STABLE_CYCLES(8),
    .SETTLE_CYCLES     (4),
    .CALIB_GAP         (3),
    .MAX_CALIB         (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .relock_req   (relock_req),
    .phase_valid  (phase_valid),
    .phase_ok     (phase_ok),
    .clkdiv_resetn(clkdiv_resetn),
    .clkdiv_calib (clkdiv_calib),
    .div_ready    (div_ready),
    .calib_count  (calib_count),
    .fault        (fault)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clkdiv_calib) begin
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
      if (!prev_calib) begin
        pulses = pulses + 1;
        if (last_start >= 0 && (cyc - last_start) < min_space)
          min_space = cyc - last_start;
        last_start = cyc;
      end
    end else begin
      run_len = 0;
    end
    prev_calib = clkdiv_calib;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at edge 0 (the edge after pll_lock became high, or after the
  // relock edge), with pll_lock already high. Returns at edge 12, the first
  // CHECK cycle. At edge 11 it drives a phase_ok=0 strobe that falls in
  // SETTLE; that strobe must be ignored.
  task automatic bring_up(input string tag);
    tick(7);
    check({tag, ".resetn_e7"}, clkdiv_resetn, 0);
    tick(1);
    check({tag, ".resetn_e8"}, clkdiv_resetn, 1);
    tick(3);
    phase_valid = 1'b1;
    phase_ok    = 1'b0;
    tick(1);
    phase_valid = 1'b0;
    check({tag, ".no_calib_in_settle"}, clkdiv_calib, 0);
  endtask

  // Called in CHECK at edge N. Applies phase_ok=0, which must produce one
  // CALIB pulse. A phase_ok=1 strobe applied inside the gap must be ignored.
  // Returns at edge N+5, back in CHECK.
  task automatic calib_round(input string tag, input int exp_cnt);
    phase_valid = 1'b1;
    phase_ok    = 1'b0;
    tick(1);
    phase_valid = 1'b0;
    check({tag, ".pulse_hi"}, clkdiv_calib, 1);
    check({tag, ".count"}, calib_count, exp_cnt);
    tick(1);
    check({tag, ".pulse_lo"}, clkdiv_calib, 0);
    tick(1);
    phase_valid = 1'b1;
    phase_ok    = 1'b1;
    tick(1);
    phase_valid = 1'b0;
    check({tag, ".gap_ignored"}, div_ready, 0);
    tick(1);
  endtask

  task automatic accept(input string tag);
    phase_valid = 1'b1;
    phase_ok    = 1'b1;
    tick(1);
    phase_valid = 1'b0;
    check({tag, ".ready"}, div_ready, 1);
  endtask

  int p0;

  initial begin
    rst         = 1'b1;
    pll_lock    = 1'b0;
    relock_req  = 1'b0;
    phase_valid = 1'b0;
    phase_ok    = 1'b0;
    tick(3);
    check("rst.resetn", clkdiv_resetn, 0);
    check("rst.calib",  clkdiv_calib,  0);
    check("rst.ready",  div_ready,     0);
    check("rst.count",  calib_count,   0);
    check("rst.fault",  fault,         0);
    rst = 1'b0;
    tick(2);

    // Clean bring-up.
    p0 = pulses;
    pll_lock = 1'b1;
    bring_up("clean");
    check("clean.ready_e12", div_ready, 0);
    accept("clean");
    check("clean.count", calib_count, 0);
    check("clean.no_pulses", pulses - p0, 0);

    // Lock loss while ready. The full sequence must repeat.
    pll_lock = 1'b0;
    tick(1);
    check("loss.ready", div_ready, 0);
    check("loss.resetn", clkdiv_resetn, 0);
    pll_lock = 1'b1;
    bring_up("relock");
    accept("relock");

    // Lock glitch: high for 5 cycles, low for 1, then high again.
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(1);
    check("glitch.resetn_low", clkdiv_resetn, 0);
    pll_lock = 1'b1;
    bring_up("glitch");

    // Three calibrations, then alignment.
    p0 = pulses;
    calib_round("cal1", 1);
    calib_round("cal2", 2);
    calib_round("cal3", 3);
    accept("cal");
    check("cal.count", calib_count, 3);
    check("cal.pulses", pulses - p0, 3);
    check("cal.width", max_run, 1);
    check("cal.spacing_ge5", int'(min_space >= 5), 1);

    // A relock request clears the count. Then exhaust all attempts.
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("relock.resetn", clkdiv_resetn, 0);
    check("relock.ready", div_ready, 0);
    check("relock.count", calib_count, 0);
    bring_up("exh");
    p0 = pulses;
    for (int i = 1; i <= 7; i++) calib_round($sformatf("exh%0d", i), i);
    phase_valid = 1'b1;
    phase_ok    = 1'b0;
    tick(1);
    phase_valid = 1'b0;
    check("exh.fault", fault, 1);
    check("exh.ready", div_ready, 0);
    check("exh.count", calib_count, 7);
    check("exh.pulses", pulses - p0, 7);
    check("exh.no_8th_pulse", clkdiv_calib, 0);
    check("exh.resetn_held", clkdiv_resetn, 1);
    tick(3);
    check("exh.fault_holds", fault, 1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("exh.relock_fault", fault, 0);
    check("exh.relock_count", calib_count, 0);
    check("exh.relock_resetn", clkdiv_resetn, 0);

    // Relock and an accepting strobe on the same edge: the relock wins.
    bring_up("race");
    phase_valid = 1'b1;
    phase_ok    = 1'b1;
    relock_req  = 1'b1;
    tick(1);
    phase_valid = 1'b0;
    relock_req  = 1'b0;
    check("race.ready", div_ready, 0);
    check("race.resetn", clkdiv_resetn, 0);

    // Relock during the CALIB pulse cycle: the pulse stays one cycle long.
    bring_up("abort");
    phase_valid = 1'b1;
    phase_ok    = 1'b0;
    tick(1);
    phase_valid = 1'b0;
    check("abort.pulse_hi", clkdiv_calib, 1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("abort.pulse_lo", clkdiv_calib, 0);
    check("abort.count", calib_count, 0);
    check("abort.resetn", clkdiv_resetn, 0);
    check("abort.width", max_run, 1);
    bring_up("abort_again");
    accept("abort_again");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
